// File: rtl/fifo_reader.sv
// fifo_reader: drains an upstream FIFO with fixed read latency into a
// credit-limited skid buffer and forwards words under downstream pause.
module fifo_reader #(
  parameter int DATA_WIDTH = 6,
  parameter int RD_LATENCY = 2,
  parameter int SKID_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  Fifo_Empty,
  input  logic                  Fifo_Almost_Empty,
  input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
  input  logic                  Pausa_in,
  output logic                  pop,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  valid_out,
  output logic                  Idle,
  output logic [3:0]            Occupancy,
  output logic                  Error_Reader
);

  localparam int PW = $clog2(SKID_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    ACTIVE = 3'b010,
    DRAIN  = 3'b100
  } state_t;

  state_t state;
  state_t state_nx;

  logic [RD_LATENCY-1:0] flight;
  logic [2:0]            flight_cnt;
  logic [4:0]            credit;
  logic                  room;
  logic                  pop_nx;

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  capture;
  logic                  remove;
  logic                  full;
  logic                  drop;
  logic                  wr_en;

  always_comb begin
    flight_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      flight_cnt = flight_cnt + 3'(flight[i]);
    end
  end

  // The pop already on the wire is not yet in the shift register.
  assign credit = 5'(flight_cnt) + 5'(Occupancy) + 5'(pop);
  assign room   = credit < 5'(SKID_DEPTH);

  assign capture = flight[RD_LATENCY-1];
  assign remove  = !Pausa_in && (Occupancy != 4'd0);
  assign full    = Occupancy == 4'(SKID_DEPTH);
  assign drop    = capture && full && !remove;
  assign wr_en   = capture && !drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state[0]: begin
        if (enable) state_nx = ACTIVE;
      end
      state[1]: begin
        if (!enable) state_nx = DRAIN;
      end
      state[2]: begin
        if (enable) begin
          state_nx = ACTIVE;
        end else if (flight_cnt == 3'd0 &&
                     Occupancy == 4'd0) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Almost-empty flag does not yet reflect the pop in flight.
  always_comb begin
    Idle   = state == IDLE;
    pop_nx = (state_nx == ACTIVE) &&
             !Fifo_Empty &&
             room &&
             !(Fifo_Almost_Empty && pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pop          <= 1'b0;
      flight       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      Occupancy    <= 4'd0;
      Data_out     <= '0;
      valid_out    <= 1'b0;
      Error_Reader <= 1'b0;
    end else begin
      pop    <= pop_nx;
      flight <= RD_LATENCY'({flight, pop});
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (remove) begin
        rd_ptr    <= rd_ptr + PW'(1);
        Data_out  <= mem[rd_ptr];
        valid_out <= 1'b1;
      end else begin
        valid_out <= 1'b0;
      end
      unique case ({wr_en, remove})
        2'b10:   Occupancy <= Occupancy + 4'd1;
        2'b01:   Occupancy <= Occupancy - 4'd1;
        default: Occupancy <= Occupancy;
      endcase
      if (drop) begin
        Error_Reader <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_ptr] <= Fifo_Data_in;
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed and random checks of fifo_reader against a
// queue-based model of the upstream FIFO, read pipe and skid buffer.
module tb_fifo_reader;

  localparam int DW = 6;
  localparam int L  = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          Fifo_Empty;
  logic          Fifo_Almost_Empty;
  logic [DW-1:0] Fifo_Data_in;
  logic          Pausa_in;
  logic          pop;
  logic [DW-1:0] Data_out;
  logic          valid_out;
  logic          Idle;
  logic [3:0]    Occupancy;
  logic          Error_Reader;

  always #5 clk = ~clk;

  fifo_reader #(
    .DATA_WIDTH(DW),
    .RD_LATENCY(L),
    .SKID_DEPTH(D)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .Fifo_Empty       (Fifo_Empty),
    .Fifo_Almost_Empty(Fifo_Almost_Empty),
    .Fifo_Data_in     (Fifo_Data_in),
    .Pausa_in         (Pausa_in),
    .pop              (pop),
    .Data_out         (Data_out),
    .valid_out        (valid_out),
    .Idle             (Idle),
    .Occupancy        (Occupancy),
    .Error_Reader     (Error_Reader)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } fl_t;

  logic [DW-1:0] fifoq[$];
  logic [DW-1:0] skid[$];
  fl_t           flq[$];

  int            cyc;
  int            checks;
  int            errors;
  int            pops;
  int            outs;
  int            first_pop;
  int            first_out;
  int            max_occ;
  logic          exp_valid;
  logic [DW-1:0] exp_data;
  logic          force_empty;
  logic          prev_empty;
  logic          prev_en_ok;
  logic          prev_pop;
  logic          prev_ae;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    Fifo_Empty        = force_empty || (fifoq.size() == 0);
    Fifo_Almost_Empty = fifoq.size() == 1;
    if (flq.size() > 0 && flq[0].due == cyc) begin
      Fifo_Data_in = flq[0].d;
    end else begin
      Fifo_Data_in = DW'($urandom);
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, check at negedge.
  task automatic tick();
    logic          p;
    logic          ps;
    logic          rs;
    logic          cap;
    logic [DW-1:0] cd;
    drive();
    p = pop;
    if (p === 1'b1) begin
      if (first_pop < 0) first_pop = cyc;
      chk("pop_underflow", 32'(fifoq.size() == 0), 0);
      chk("pop_after_empty", 32'(prev_empty), 0);
      chk("pop_not_active", 32'(prev_en_ok), 1);
      chk("pop_ae_guard", 32'(prev_pop && prev_ae), 0);
      chk("pop_credit", 32'(flq.size() + skid.size() + 1 <= D), 1);
    end
    prev_empty = Fifo_Empty;
    prev_en_ok = enable && !reset;
    prev_ae    = Fifo_Almost_Empty;
    prev_pop   = (p === 1'b1);
    ps  = Pausa_in;
    rs  = reset;
    cap = flq.size() > 0 && flq[0].due == cyc;
    cd  = Fifo_Data_in;
    @(posedge clk);
    if (p === 1'b1) pops++;
    if (rs) begin
      if (p === 1'b1 && fifoq.size() > 0) void'(fifoq.pop_front());
      flq.delete();
      skid.delete();
      exp_valid = 1'b0;
      exp_data  = '0;
    end else begin
      if (cap) void'(flq.pop_front());
      if (p === 1'b1 && fifoq.size() > 0) begin
        flq.push_back('{cyc + L, fifoq.pop_front()});
      end
      exp_valid = !ps && skid.size() > 0;
      if (exp_valid) begin
        exp_data = skid.pop_front();
        outs++;
        if (first_out < 0) first_out = cyc + 1;
      end
      if (cap && skid.size() < D) skid.push_back(cd);
    end
    cyc++;
    @(negedge clk);
    if (32'(Occupancy) > 32'(max_occ)) max_occ = int'(Occupancy);
    chk("valid_out", 32'(valid_out), 32'(exp_valid));
    chk("data_out", 32'(Data_out), 32'(exp_data));
    chk("occupancy", 32'(Occupancy), 32'(skid.size()));
    chk("error_reader", 32'(Error_Reader), 0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    pops        = 0;
    outs        = 0;
    first_pop   = -1;
    first_out   = -1;
    max_occ     = 0;
    exp_valid   = 1'b0;
    exp_data    = '0;
    force_empty = 1'b0;
    prev_empty  = 1'b1;
    prev_en_ok  = 1'b0;
    prev_pop    = 1'b0;
    prev_ae     = 1'b0;
    reset       = 1'b1;
    enable      = 1'b0;
    Pausa_in    = 1'b0;

    // reset state
    tick();
    tick();
    chk("reset_idle", 32'(Idle), 1);
    chk("reset_pop", 32'(pop), 0);
    chk("reset_data", 32'(Data_out), 0);

    // three words, free-flowing output
    reset = 1'b0;
    fifoq = '{6'h01, 6'h02, 6'h03};
    enable = 1'b1;
    first_pop = -1;
    first_out = -1;
    outs = 0;
    repeat (12) tick();
    chk("t034_latency", 32'(first_out - first_pop), L + 2);
    chk("t034_count", 32'(outs), 3);
    chk("t034_last", 32'(Data_out), 32'h03);
    enable = 1'b0;
    repeat (4) tick();
    chk("t034_idle", 32'(Idle), 1);

    // downstream paused: credit limit stops popping
    Pausa_in = 1'b1;
    pops = 0;
    for (int i = 0; i < 8; i++) fifoq.push_back(DW'($urandom));
    enable = 1'b1;
    repeat (20) tick();
    chk("t035_pops", 32'(pops), 4);
    chk("t035_occ", 32'(Occupancy), 4);
    chk("t035_pop_hold", 32'(pop), 0);
    Pausa_in = 1'b0;
    outs = 0;
    repeat (30) tick();
    chk("t035_outs", 32'(outs), 8);
    chk("t035_pops_all", 32'(pops), 8);
    enable = 1'b0;
    repeat (4) tick();

    // single word with almost-empty flag
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pops = 0;
    outs = 0;
    fifoq.push_back(6'h2A);
    enable = 1'b1;
    repeat (10) tick();
    chk("t036_pops", 32'(pops), 1);
    chk("t036_outs", 32'(outs), 1);
    chk("t036_data", 32'(Data_out), 32'h2A);
    enable = 1'b0;
    repeat (4) tick();

    // enable drop with two words in flight
    for (int i = 0; i < 6; i++) fifoq.push_back(DW'($urandom));
    pops = 0;
    outs = 0;
    first_pop = -1;
    enable = 1'b1;
    for (int i = 0; i < 10 && first_pop < 0; i++) tick();
    chk("t037_started", 32'(first_pop >= 0), 1);
    enable = 1'b0;
    tick();
    chk("t037_drain_busy", 32'(Idle), 0);
    repeat (10) tick();
    chk("t037_pops", 32'(pops), 2);
    chk("t037_outs", 32'(outs), 2);
    chk("t037_idle", 32'(Idle), 1);
    fifoq.delete();

    // reset with buffered words
    for (int i = 0; i < 3; i++) fifoq.push_back(DW'($urandom));
    Pausa_in = 1'b1;
    enable = 1'b1;
    repeat (12) tick();
    chk("t038_occ_pre", 32'(Occupancy), 3);
    reset = 1'b1;
    tick();
    chk("t038_occ", 32'(Occupancy), 0);
    chk("t038_valid", 32'(valid_out), 0);
    chk("t038_idle", 32'(Idle), 1);
    reset = 1'b0;
    Pausa_in = 1'b0;
    enable = 1'b0;
    outs = 0;
    repeat (10) tick();
    chk("t038_no_stale", 32'(outs), 0);

    // random traffic against the model
    enable = 1'b1;
    max_occ = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0 && fifoq.size() < 16) begin
        fifoq.push_back(DW'($urandom));
      end
      Pausa_in    = 1'($urandom_range(0, 1));
      force_empty = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) enable = !enable;
      tick();
    end
    force_empty = 1'b0;
    Pausa_in = 1'b0;
    enable = 1'b0;
    repeat (20) tick();
    chk("rand_max_occ", 32'(max_occ <= D), 1);
    chk("rand_occ_end", 32'(Occupancy), 0);
    chk("rand_idle_end", 32'(Idle), 1);
    chk("rand_error", 32'(Error_Reader), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 6: width of every data path.
REQ-002 Parameter RD_LATENCY, default 2: cycles from pop sampled high to matching Fifo_Data_in valid; legal range 1..4.
REQ-003 Parameter SKID_DEPTH, default 4: entries in internal skid buffer; power of two, 2..8.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous reset, active-high.
REQ-006 enable  input  1  request to drain upstream FIFO.
REQ-007 Fifo_Empty  input  1  upstream FIFO empty flag.
REQ-008 Fifo_Almost_Empty  input  1  upstream FIFO holds one entry.
REQ-009 Fifo_Data_in  input  DATA_WIDTH  read data returned by upstream FIFO.
REQ-010 Pausa_in  input  1  downstream backpressure; 1 = hold output.
REQ-011 pop  output  1  registered read request to upstream FIFO.
REQ-012 Data_out  output  DATA_WIDTH  registered forwarded data.
REQ-013 valid_out  output  1  Data_out carries a new word this cycle.
REQ-014 Idle  output  1  state machine in IDLE.
REQ-015 Occupancy  output  4  skid entries currently held.
REQ-016 Error_Reader  output  1  sticky overflow error.

Function
REQ-017 States: IDLE, ACTIVE, DRAIN; encoding free.
REQ-018 IDLE->ACTIVE when enable=1; ACTIVE->DRAIN when enable=0; DRAIN->ACTIVE when enable=1; DRAIN->IDLE when in-flight count=0 and Occupancy=0.
REQ-019 pop shall assert only in ACTIVE, with Fifo_Empty=0 and (in-flight + Occupancy) < SKID_DEPTH.
REQ-020 When Fifo_Almost_Empty=1, pop shall not assert in the cycle after a pop=1 cycle (flag lag guard); consecutive pops otherwise allowed.
REQ-021 In-flight tracking: RD_LATENCY-stage valid shift register fed by pop; in-flight count = number of set stages.
REQ-022 When final shift stage is 1, Fifo_Data_in shall be written to skid tail at that edge.
REQ-023 Each cycle with Pausa_in=0 and Occupancy>0: Data_out <= skid head, valid_out <= 1, head removed; otherwise valid_out <= 0 and Data_out holds last value.
REQ-024 Simultaneous capture and removal: Occupancy unchanged; capture into empty skid is not forwarded same edge.
REQ-025 Latency: pop high in cycle t, Pausa_in=0, skid empty -> valid_out high in cycle t+RD_LATENCY+2 with that word.
REQ-026 Order preserved: output words in pop order, no loss, no duplication.
REQ-027 Pointers wrap modulo SKID_DEPTH; Occupancy width covers 0..SKID_DEPTH.
REQ-028 Capture with Occupancy=SKID_DEPTH and no removal shall drop the word and set Error_Reader; unreachable under REQ-019.
REQ-029 Pausa_in does not stop pop; credit rule REQ-019 alone bounds in-flight data.
REQ-030 DRAIN: pop=0; in-flight words still captured and forwarded.

Reset
REQ-031 reset sampled high: pop=0, valid_out=0, Data_out=0, Occupancy=0, Error_Reader=0, Idle=1, state IDLE, shift register and pointers cleared, from the next cycle.
REQ-032 Reset mid-operation discards in-flight and buffered words; Fifo_Data_in ignored until new pops.
REQ-033 Error_Reader clears only on reset.

Verification
REQ-034 FIFO holds 3 words 0x01,0x02,0x03, enable=1, Pausa_in=0 -> Data_out 0x01,0x02,0x03 in order, first valid_out 4 cycles after first pop, Error_Reader=0.
REQ-035 Pausa_in=1 throughout, FIFO holds 8 words -> exactly 4 pops, Occupancy=4, pop stays 0; release Pausa -> 4 words out, popping resumes.
REQ-036 Fifo_Almost_Empty=1, one word 0x2A -> single pop, no pop next cycle, Data_out=0x2A once.
REQ-037 enable dropped with 2 words in flight -> state DRAIN, pop=0, both words forwarded, then Idle=1.
REQ-038 reset asserted with Occupancy=3 -> next cycle Occupancy=0, valid_out=0, Idle=1, no stale word ever output.
REQ-039 Random Pausa_in and Fifo_Empty for 10000 cycles -> scoreboard match, Occupancy never exceeds 4, Error_Reader=0.
